// File: rtl/edge_evt_pkg.sv
// Shared constants and helpers for the edge event arbiter.
// Edge direction encoding, default channel count, channel index width.
package edge_evt_pkg;

  localparam logic EVT_FALL = 1'b0;
  localparam logic EVT_RISE = 1'b1;

  localparam int DEF_NCH = 4;

  // A channel index is never narrower than one bit.
  function automatic int ch_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Valid/ready event port: channel index plus edge direction.
// The producer drives valid/ch/rise and the consumer drives ready.
interface edge_event_arbiter_if #(
  parameter int CH_W = 2
);

  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_ch;
  logic            evt_rise;

  modport master (
    output evt_valid,
    output evt_ch,
    output evt_rise,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_ch,
    input  evt_rise,
    output evt_ready
  );

endinterface

// File: rtl/edge_event_cell.sv
// One channel: input sampling with priming, edge detection, and the
// pending/type/overflow state that the arbiter drains via i_grant.
module edge_event_cell (
  input  logic clk,
  input  logic rst,
  input  logic i_din,
  input  logic i_grant,
  input  logic i_ovf_clr,
  output logic o_pending,
  output logic o_type,
  output logic o_ovf
);

  logic r_prime;
  logic r_s;
  logic r_p;
  logic r_pending;
  logic r_type;
  logic r_ovf;

  logic w_edge;
  logic w_lost;

  // Until primed, s and p both load din so a level held through reset is not an edge.
  assign w_edge = r_prime & (r_s ^ r_p);
  assign w_lost = w_edge & r_pending & ~i_grant;

  // Sampling pipeline and prime flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prime <= 1'b0;
      r_s     <= 1'b0;
      r_p     <= 1'b0;
    end else begin
      r_prime <= 1'b1;
      r_s     <= i_din;
      r_p     <= r_prime ? r_s : i_din;
    end
  end

  // A new edge beats a concurrent grant; the grant carries the previous type.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= 1'b0;
      r_type    <= 1'b0;
    end else if (w_edge) begin
      r_pending <= 1'b1;
      r_type    <= r_s;
    end else if (i_grant) begin
      r_pending <= 1'b0;
    end
  end

  // Sticky overflow; a fresh loss outranks the clear pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_lost) begin
      r_ovf <= 1'b1;
    end else if (i_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign o_pending = r_pending;
  assign o_type    = r_type;
  assign o_ovf     = r_ovf;

endmodule

// File: rtl/edge_event_arbiter.sv
// Either-edge event collector: per-channel cells feed a round-robin
// arbiter that loads a single valid/ready event slot.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int NCH  = DEF_NCH,
  parameter int CH_W = ch_width(NCH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          din,
  input  logic [NCH-1:0]          ovf_clr,
  output logic [NCH-1:0]          ovf,
  edge_event_arbiter_if.master    evt
);

  localparam int SW = CH_W + 1;

  logic [NCH-1:0]  w_pending;
  logic [NCH-1:0]  w_type;
  logic [NCH-1:0]  w_grant;
  logic            w_slot_free;
  logic            w_found;
  logic [CH_W-1:0] w_sel;
  logic [CH_W-1:0] w_idx;
  logic [SW-1:0]   w_sum;
  logic [CH_W-1:0] w_rr_next;

  logic            r_valid;
  logic [CH_W-1:0] r_ch;
  logic            r_rise;
  logic [CH_W-1:0] r_rr;

  for (genvar g = 0; g < NCH; g++) begin : g_cell
    edge_event_cell u_cell (
      .clk       (clk),
      .rst       (rst),
      .i_din     (din[g]),
      .i_grant   (w_grant[g]),
      .i_ovf_clr (ovf_clr[g]),
      .o_pending (w_pending[g]),
      .o_type    (w_type[g]),
      .o_ovf     (ovf[g])
    );
  end

  // Accepting and reloading happen in the same cycle.
  assign w_slot_free = ~r_valid | evt.evt_ready;

  // First pending channel at or after rr, wrapping modulo NCH.
  always_comb begin
    w_found = 1'b0;
    w_sel   = {CH_W{1'b0}};
    w_sum   = {SW{1'b0}};
    w_idx   = {CH_W{1'b0}};
    for (int k = 0; k < NCH; k++) begin
      w_sum = {1'b0, r_rr} + SW'(k);
      if (w_sum >= SW'(NCH)) begin
        w_sum = w_sum - SW'(NCH);
      end else begin
        w_sum = w_sum;
      end
      w_idx = w_sum[CH_W-1:0];
      if (!w_found && w_pending[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end else begin
        w_found = w_found;
      end
    end
  end

  // One-hot grant back to the winning cell and the pointer that follows it.
  always_comb begin
    w_grant   = {NCH{1'b0}};
    w_rr_next = r_rr;
    if (w_slot_free && w_found) begin
      w_grant[w_sel] = 1'b1;
      if (w_sel == CH_W'(NCH - 1)) begin
        w_rr_next = {CH_W{1'b0}};
      end else begin
        w_rr_next = w_sel + CH_W'(1);
      end
    end else begin
      w_grant   = {NCH{1'b0}};
      w_rr_next = r_rr;
    end
  end

  // Event slot and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ch    <= {CH_W{1'b0}};
      r_rise  <= EVT_FALL;
      r_rr    <= {CH_W{1'b0}};
    end else if (w_slot_free) begin
      if (w_found) begin
        r_valid <= 1'b1;
        r_ch    <= w_sel;
        r_rise  <= w_type[w_sel];
        r_rr    <= w_rr_next;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign evt.evt_valid = r_valid;
  assign evt.evt_ch    = r_ch;
  assign evt.evt_rise  = r_rise;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scenario bench for edge_event_arbiter: expected events are queued when
// edges are driven and compared in order against observed transfers.
module tb_edge_event_arbiter;
  import edge_evt_pkg::*;

  localparam int NCH  = 4;
  localparam int CH_W = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] din;
  logic [NCH-1:0] ovf_clr;
  logic [NCH-1:0] ovf;

  edge_event_arbiter_if #(.CH_W(CH_W)) bus ();

  edge_event_arbiter #(.NCH(NCH), .CH_W(CH_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .ovf_clr (ovf_clr),
    .ovf     (ovf),
    .evt     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int obs_rd   = 0;

  logic [CH_W:0] exp_q[$];
  logic [CH_W:0] obs_q[$];
  int            obs_t[$];
  logic [CH_W:0] exp_e;
  logic [CH_W:0] obs_e;

  always @(posedge clk) cyc <= cyc + 1;

  // Transfer monitor: ready is only changed just after posedge, so a
  // valid&&ready seen at negedge completes at the next posedge.
  always @(negedge clk) begin
    if (!rst && bus.evt_valid && bus.evt_ready) begin
      obs_q.push_back({bus.evt_ch, bus.evt_rise});
      obs_t.push_back(cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_obs(input int budget);
    for (int n = 0; n < budget && (obs_q.size() - obs_rd) < exp_q.size(); n++) tick();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; din = 4'b1010; ovf_clr = 4'b0000; bus.evt_ready = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({bus.evt_valid, bus.evt_ch, bus.evt_rise, ovf} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%0b ch=%0d rise=%0b ovf=%b, required all 0",
               bus.evt_valid, bus.evt_ch, bus.evt_rise, ovf);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (bus.evt_valid !== 1'b0 || ovf !== 4'b0000) begin
        n_fail++;
        $display("FAIL prime_idle: cycle %0d valid=%0b ovf=%b, required valid=0 ovf=0000",
                 i, bus.evt_valid, ovf);
      end
    end
    n_checks++;
    if (obs_q.size() !== 0) begin
      n_fail++;
      $display("FAIL prime_no_event: %0d events observed, required 0", obs_q.size());
    end
  endtask

  task automatic test_single_latency();
    din[2] = 1'b1; exp_q.push_back({2'd2, EVT_RISE});
    tick(); tick();
    n_checks++;
    if (bus.evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_early: valid=%0b after k+1, required 0", bus.evt_valid);
    end
    tick();
    n_checks++;
    if ({bus.evt_valid, bus.evt_ch, bus.evt_rise} !== {1'b1, 2'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL lat_k2: valid=%0b ch=%0d rise=%0b, required valid=1 ch=2 rise=1",
               bus.evt_valid, bus.evt_ch, bus.evt_rise);
    end
    tick();
    n_checks++;
    if (bus.evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_one_cycle: valid=%0b at k+3, required 0", bus.evt_valid);
    end
    din[2] = 1'b0; exp_q.push_back({2'd2, EVT_FALL});
    wait_obs(40);
    n_checks++;
    if (obs_q.size() - obs_rd != exp_q.size()) begin
      n_fail++;
      $display("FAIL lat_count: observed %0d events, required %0d", obs_q.size() - obs_rd, exp_q.size());
    end
    while (exp_q.size() != 0 && obs_rd < obs_q.size()) begin
      exp_e = exp_q.pop_front(); obs_e = obs_q[obs_rd]; obs_rd++; n_checks++;
      if (obs_e !== exp_e) begin
        n_fail++;
        $display("FAIL lat_event: ch=%0d rise=%0b, required ch=%0d rise=%0b",
                 obs_e[CH_W:1], obs_e[0], exp_e[CH_W:1], exp_e[0]);
      end
    end
    exp_q.delete(); obs_rd = obs_q.size();
  endtask

  task automatic test_round_robin();
    int base;
    // rr is 3 here; these two falls bring rr back to 0 and all inputs low.
    din[1] = 1'b0; exp_q.push_back({2'd1, EVT_FALL});
    repeat (8) tick();
    din[3] = 1'b0; exp_q.push_back({2'd3, EVT_FALL});
    repeat (8) tick();
    base = obs_q.size();
    din = 4'b1011;
    exp_q.push_back({2'd0, EVT_RISE});
    exp_q.push_back({2'd1, EVT_RISE});
    exp_q.push_back({2'd3, EVT_RISE});
    repeat (10) tick();
    din = 4'b0010;
    exp_q.push_back({2'd0, EVT_FALL});
    exp_q.push_back({2'd3, EVT_FALL});
    wait_obs(60);
    n_checks++;
    if (obs_q.size() < base + 3) begin
      n_fail++;
      $display("FAIL rr_back_to_back: only %0d events after stage start, required 3", obs_q.size() - base);
    end else if (obs_t[base + 2] - obs_t[base] != 2) begin
      n_fail++;
      $display("FAIL rr_back_to_back: 3 events spanned %0d cycles, required 2", obs_t[base + 2] - obs_t[base]);
    end
    n_checks++;
    if (obs_q.size() - obs_rd != exp_q.size()) begin
      n_fail++;
      $display("FAIL rr_count: observed %0d events, required %0d", obs_q.size() - obs_rd, exp_q.size());
    end
    while (exp_q.size() != 0 && obs_rd < obs_q.size()) begin
      exp_e = exp_q.pop_front(); obs_e = obs_q[obs_rd]; obs_rd++; n_checks++;
      if (obs_e !== exp_e) begin
        n_fail++;
        $display("FAIL rr_event: ch=%0d rise=%0b, required ch=%0d rise=%0b",
                 obs_e[CH_W:1], obs_e[0], exp_e[CH_W:1], exp_e[0]);
      end
    end
    exp_q.delete(); obs_rd = obs_q.size();
  endtask

  task automatic test_backpressure();
    din[1] = 1'b0; exp_q.push_back({2'd1, EVT_FALL});
    repeat (8) tick();
    bus.evt_ready = 1'b0;
    din[1] = 1'b1; exp_q.push_back({2'd1, EVT_RISE});
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i >= 2) begin
        n_checks++;
        if ({bus.evt_valid, bus.evt_ch, bus.evt_rise, ovf} !== {1'b1, 2'd1, 1'b1, 4'b0000}) begin
          n_fail++;
          $display("FAIL bp_hold: cycle %0d valid=%0b ch=%0d rise=%0b ovf=%b, required 1/1/1/0000",
                   i, bus.evt_valid, bus.evt_ch, bus.evt_rise, ovf);
        end
      end
    end
    bus.evt_ready = 1'b1;
    wait_obs(40);
    n_checks++;
    if (obs_q.size() - obs_rd != exp_q.size()) begin
      n_fail++;
      $display("FAIL bp_count: observed %0d events, required %0d", obs_q.size() - obs_rd, exp_q.size());
    end
    while (exp_q.size() != 0 && obs_rd < obs_q.size()) begin
      exp_e = exp_q.pop_front(); obs_e = obs_q[obs_rd]; obs_rd++; n_checks++;
      if (obs_e !== exp_e) begin
        n_fail++;
        $display("FAIL bp_event: ch=%0d rise=%0b, required ch=%0d rise=%0b",
                 obs_e[CH_W:1], obs_e[0], exp_e[CH_W:1], exp_e[0]);
      end
    end
    exp_q.delete(); obs_rd = obs_q.size();
  endtask

  task automatic test_overflow();
    bus.evt_ready = 1'b0;
    din[0] = 1'b1; exp_q.push_back({2'd0, EVT_RISE});
    repeat (4) tick();
    din[2] = 1'b1;
    repeat (3) tick();
    din[2] = 1'b0; exp_q.push_back({2'd2, EVT_FALL});
    repeat (3) tick();
    n_checks++;
    if ({ovf, bus.evt_valid, bus.evt_ch} !== {4'b0100, 1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL ovf_set: ovf=%b valid=%0b ch=%0d, required ovf=0100 valid=1 ch=0",
               ovf, bus.evt_valid, bus.evt_ch);
    end
    bus.evt_ready = 1'b1;
    wait_obs(40);
    n_checks++;
    if (obs_q.size() - obs_rd != exp_q.size()) begin
      n_fail++;
      $display("FAIL ovf_count: observed %0d events, required %0d", obs_q.size() - obs_rd, exp_q.size());
    end
    while (exp_q.size() != 0 && obs_rd < obs_q.size()) begin
      exp_e = exp_q.pop_front(); obs_e = obs_q[obs_rd]; obs_rd++; n_checks++;
      if (obs_e !== exp_e) begin
        n_fail++;
        $display("FAIL ovf_event: ch=%0d rise=%0b, required ch=%0d rise=%0b",
                 obs_e[CH_W:1], obs_e[0], exp_e[CH_W:1], exp_e[0]);
      end
    end
    exp_q.delete(); obs_rd = obs_q.size();
    n_checks++;
    if (ovf !== 4'b0100) begin
      n_fail++;
      $display("FAIL ovf_sticky: ovf=%b, required 0100", ovf);
    end
    ovf_clr = 4'b0100;
    tick();
    ovf_clr = 4'b0000;
    n_checks++;
    if (ovf !== 4'b0000) begin
      n_fail++;
      $display("FAIL ovf_clear: ovf=%b, required 0000", ovf);
    end
  endtask

  task automatic test_reset_mid();
    bus.evt_ready = 1'b0;
    din[3] = 1'b1;
    repeat (4) tick();
    din[0] = 1'b0; din[1] = 1'b0; din[2] = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({bus.evt_valid, bus.evt_ch} !== {1'b1, 2'd3}) begin
      n_fail++;
      $display("FAIL rstmid_pre: valid=%0b ch=%0d, required valid=1 ch=3", bus.evt_valid, bus.evt_ch);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.evt_valid, bus.evt_ch, bus.evt_rise, ovf} !== 8'h00) begin
      n_fail++;
      $display("FAIL rstmid_async: valid=%0b ch=%0d rise=%0b ovf=%b, required all 0",
               bus.evt_valid, bus.evt_ch, bus.evt_rise, ovf);
    end
    repeat (2) tick();
    rst = 1'b0; bus.evt_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (bus.evt_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_quiet: cycle %0d valid=%0b, required 0", i, bus.evt_valid);
      end
    end
    din[1] = 1'b1; exp_q.push_back({2'd1, EVT_RISE});
    wait_obs(40);
    n_checks++;
    if (obs_q.size() - obs_rd != exp_q.size()) begin
      n_fail++;
      $display("FAIL rstmid_count: observed %0d events, required %0d", obs_q.size() - obs_rd, exp_q.size());
    end
    while (exp_q.size() != 0 && obs_rd < obs_q.size()) begin
      exp_e = exp_q.pop_front(); obs_e = obs_q[obs_rd]; obs_rd++; n_checks++;
      if (obs_e !== exp_e) begin
        n_fail++;
        $display("FAIL rstmid_event: ch=%0d rise=%0b, required ch=%0d rise=%0b",
                 obs_e[CH_W:1], obs_e[0], exp_e[CH_W:1], exp_e[0]);
      end
    end
    exp_q.delete(); obs_rd = obs_q.size();
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
